// File: rtl/rr_arbiter_n.sv
// N-way round-robin arbiter with per-grant time quantum, early release on last,
// and lock override of quantum expiry. All outputs are registered.
module rr_arbiter_n #(
    parameter int  NUM_REQ = 4,
    parameter int  QUANTUM = 16,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] last,
    input  logic [NUM_REQ-1:0] lock,
    output logic [NUM_REQ-1:0] grnt,
    output logic               grnt_valid,
    output logic [IDX_W-1:0]   grnt_idx,
    output logic               quantum_exp
);

    localparam int               TMR_W    = (QUANTUM > 2) ? $clog2(QUANTUM) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(QUANTUM - 1);
    localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(NUM_REQ - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [NUM_REQ-1:0] grnt_d;
    logic [IDX_W-1:0]   idx_d;
    logic               qexp_d;

    // Returns {found, index} of the first set bit of mask scanning upward from start.
    function automatic logic [IDX_W:0] pick(input logic [NUM_REQ-1:0] mask,
                                            input logic [IDX_W-1:0]   start);
        logic [IDX_W:0] res;
        int             j;
        res = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(start) + k) % NUM_REQ;
            if (!res[IDX_W] && mask[j]) begin
                res = {1'b1, IDX_W'(j)};
            end
        end
        return res;
    endfunction

    logic [IDX_W-1:0]   nxt_idx;
    logic [NUM_REQ-1:0] others;
    logic               rel_ab, rel_c, at_quantum;
    logic [IDX_W:0]     idle_pick, rel_pick;

    assign nxt_idx    = (grnt_idx == IDX_MAX) ? '0 : grnt_idx + 1'b1;
    assign others     = req & ~grnt;
    assign at_quantum = (timer_q == TMR_LAST);
    assign rel_ab     = !req[grnt_idx] || last[grnt_idx];
    assign rel_c      = at_quantum && !lock[grnt_idx] && (|others);
    assign idle_pick  = pick(req, ptr_q);
    assign rel_pick   = pick(others, nxt_idx);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        timer_d = timer_q;
        grnt_d  = grnt;
        idx_d   = grnt_idx;
        qexp_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (idle_pick[IDX_W]) begin
                    state_d = GRANT;
                    idx_d   = idle_pick[IDX_W-1:0];
                    grnt_d  = NUM_REQ'(1) << idle_pick[IDX_W-1:0];
                    timer_d = '0;
                end
            end
            GRANT: begin
                if (rel_ab || rel_c) begin
                    ptr_d   = nxt_idx;
                    timer_d = '0;
                    // A quantum handover is flagged only when no holder-side release coincides.
                    qexp_d  = !rel_ab;
                    if (rel_pick[IDX_W]) begin
                        idx_d  = rel_pick[IDX_W-1:0];
                        grnt_d = NUM_REQ'(1) << rel_pick[IDX_W-1:0];
                    end else begin
                        state_d = IDLE;
                        idx_d   = '0;
                        grnt_d  = '0;
                    end
                end else begin
                    timer_d = at_quantum ? '0 : timer_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            timer_q     <= '0;
            grnt        <= '0;
            grnt_valid  <= 1'b0;
            grnt_idx    <= '0;
            quantum_exp <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            timer_q     <= timer_d;
            grnt        <= grnt_d;
            grnt_valid  <= |grnt_d;
            grnt_idx    <= idx_d;
            quantum_exp <= qexp_d;
        end
    end

endmodule
